// File: rtl/otter_pkg.sv
// Shared types for the OTTER data-memory arbiter: arbitration FSM states
// and the identity of a port owner / read-return owner.
package otter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_OWN    = 2'd1,
        DMA_OWN    = 2'd2,
        DMA_LOCKED = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/otter_dmem_arbiter.sv
// Two-master (CPU, DMA) arbiter in front of the single OTTER data-memory
// port. Grant is combinational so a lone requester is served in the same
// cycle; contested cycles alternate round-robin, and a locked DMA burst
// keeps the port except for one forced CPU slot every MAX_LOCK cycles of
// CPU waiting. Read data returns one cycle later to whoever issued it.
module otter_dmem_arbiter
    import otter_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    // CPU request / response
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_DIN,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic        CPU_GNT,
    output logic        CPU_RVALID,
    output logic [31:0] CPU_RDATA,
    output logic        CPU_STALL,
    // DMA request / response
    input  logic        DMA_REQ,
    input  logic        DMA_WE,
    input  logic [31:0] DMA_ADDR,
    input  logic [31:0] DMA_DIN,
    input  logic [1:0]  DMA_SIZE,
    input  logic        DMA_SIGN,
    input  logic        DMA_LOCK,
    output logic        DMA_GNT,
    output logic        DMA_RVALID,
    output logic [31:0] DMA_RDATA,
    // memory data port
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    arb_state_t       state_r,    state_nxt_s;
    owner_t           last_win_r, last_win_nxt_s;
    owner_t           rd_owner_r, rd_owner_nxt_s;
    logic [CNT_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
    owner_t           gnt_s;
    logic             lock_active_s;

    // The burst lock only holds while DMA keeps both REQ and LOCK high.
    assign lock_active_s = (state_r == DMA_LOCKED) && DMA_REQ && DMA_LOCK;

    // Pick this cycle's owner: lock (with starvation break), then round-robin, then lone requester.
    always_comb begin
        gnt_s = NONE;
        if (!RST_N) begin
            gnt_s = NONE;
        end else if (lock_active_s) begin
            if (CPU_REQ && (lock_cnt_r == LOCK_LIMIT)) begin
                gnt_s = CPU;
            end else begin
                gnt_s = DMA;
            end
        end else if (CPU_REQ && DMA_REQ) begin
            if (last_win_r == CPU) begin
                gnt_s = DMA;
            end else begin
                gnt_s = CPU;
            end
        end else if (CPU_REQ) begin
            gnt_s = CPU;
        end else if (DMA_REQ) begin
            gnt_s = DMA;
        end else begin
            gnt_s = NONE;
        end
    end

    // Compute next FSM state, round-robin winner, lock counter and read-return owner.
    always_comb begin
        state_nxt_s    = IDLE;
        lock_cnt_nxt_s = {CNT_W{1'b0}};
        last_win_nxt_s = last_win_r;
        rd_owner_nxt_s = NONE;

        if (CPU_REQ && DMA_REQ && (gnt_s != NONE)) begin
            last_win_nxt_s = gnt_s;
        end else begin
            last_win_nxt_s = last_win_r;
        end

        if (lock_active_s) begin
            // Stay locked through the forced CPU slot so the burst resumes.
            state_nxt_s = DMA_LOCKED;
            if (gnt_s == CPU) begin
                lock_cnt_nxt_s = {CNT_W{1'b0}};
            end else if (CPU_REQ && (lock_cnt_r < LOCK_LIMIT)) begin
                lock_cnt_nxt_s = lock_cnt_r + CNT_W'(1);
            end else if (CPU_REQ) begin
                lock_cnt_nxt_s = lock_cnt_r;
            end else begin
                lock_cnt_nxt_s = {CNT_W{1'b0}};
            end
        end else if (state_r == DMA_LOCKED) begin
            state_nxt_s    = IDLE;
            lock_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case (gnt_s)
                CPU: state_nxt_s = CPU_OWN;
                DMA: begin
                    if (DMA_LOCK) begin
                        // The entry cycle already counts as one CPU wait.
                        state_nxt_s    = DMA_LOCKED;
                        lock_cnt_nxt_s = CPU_REQ ? CNT_W'(1) : {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = DMA_OWN;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end

        case (gnt_s)
            CPU:     rd_owner_nxt_s = CPU_WE ? NONE : CPU;
            DMA:     rd_owner_nxt_s = DMA_WE ? NONE : DMA;
            default: rd_owner_nxt_s = NONE;
        endcase
    end

    // Arbitration state; reset makes CPU the first conflict winner and drops in-flight reads.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            last_win_r <= DMA;
            lock_cnt_r <= {CNT_W{1'b0}};
            rd_owner_r <= NONE;
        end else begin
            state_r    <= state_nxt_s;
            last_win_r <= last_win_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            rd_owner_r <= rd_owner_nxt_s;
        end
    end

    // Grants, stall, read returns and the memory-port mux; everything is 0 while in reset.
    always_comb begin
        CPU_GNT    = RST_N && (gnt_s == CPU);
        DMA_GNT    = RST_N && (gnt_s == DMA);
        CPU_STALL  = RST_N && CPU_REQ && (gnt_s != CPU);
        CPU_RVALID = RST_N && (rd_owner_r == CPU);
        DMA_RVALID = RST_N && (rd_owner_r == DMA);
        CPU_RDATA  = CPU_RVALID ? MEM_DOUT2 : 32'h0000_0000;
        DMA_RDATA  = DMA_RVALID ? MEM_DOUT2 : 32'h0000_0000;
        MEM_ADDR2  = 32'h0000_0000;
        MEM_DIN2   = 32'h0000_0000;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        MEM_SIZE   = 2'b00;
        MEM_SIGN   = 1'b0;
        case (gnt_s)
            CPU: begin
                MEM_ADDR2  = CPU_ADDR;
                MEM_DIN2   = CPU_DIN;
                MEM_WRITE2 = CPU_WE;
                MEM_READ2  = !CPU_WE;
                MEM_SIZE   = CPU_SIZE;
                MEM_SIGN   = CPU_SIGN;
            end
            DMA: begin
                MEM_ADDR2  = DMA_ADDR;
                MEM_DIN2   = DMA_DIN;
                MEM_WRITE2 = DMA_WE;
                MEM_READ2  = !DMA_WE;
                MEM_SIZE   = DMA_SIZE;
                MEM_SIGN   = DMA_SIGN;
            end
            default: begin
                MEM_ADDR2  = 32'h0000_0000;
                MEM_DIN2   = 32'h0000_0000;
                MEM_WRITE2 = 1'b0;
                MEM_READ2  = 1'b0;
                MEM_SIZE   = 2'b00;
                MEM_SIGN   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Directed bench for otter_dmem_arbiter: a per-cycle vector table for the
// basic grant / read-return / write paths, plus hand-written sequences for
// the locked burst, lock exit and reset with a read in flight.
module tb_otter_dmem_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        CPU_REQ, CPU_WE, CPU_SIGN;
    logic [31:0] CPU_ADDR, CPU_DIN;
    logic [1:0]  CPU_SIZE;
    logic        CPU_GNT, CPU_RVALID, CPU_STALL;
    logic [31:0] CPU_RDATA;
    logic        DMA_REQ, DMA_WE, DMA_SIGN, DMA_LOCK;
    logic [31:0] DMA_ADDR, DMA_DIN;
    logic [1:0]  DMA_SIZE;
    logic        DMA_GNT, DMA_RVALID;
    logic [31:0] DMA_RDATA;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [1:0]  MEM_SIZE;

    int n_tests = 0;
    int n_fail  = 0;

    otter_dmem_arbiter #(.MAX_LOCK(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
        .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA), .CPU_STALL(CPU_STALL),
        .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_DIN(DMA_DIN),
        .DMA_SIZE(DMA_SIZE), .DMA_SIGN(DMA_SIGN), .DMA_LOCK(DMA_LOCK),
        .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_RDATA(DMA_RDATA),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        cr, cwe, csg;
        logic [31:0] ca, cd;
        logic [1:0]  cs;
        logic        dr, dwe, dsg, dl;
        logic [31:0] da, dd;
        logic [1:0]  ds;
        logic [31:0] md;
        logic [9:0]  e_ctl;  // {cgnt, crvalid, cstall, dgnt, drvalid, mwrite, mread, msize, msign}
        logic [31:0] e_crd, e_drd, e_maddr, e_mdin;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t vz();
        vec_t v;
        v.cr = 1'b0; v.cwe = 1'b0; v.csg = 1'b0; v.ca = 32'h0; v.cd = 32'h0; v.cs = 2'd0;
        v.dr = 1'b0; v.dwe = 1'b0; v.dsg = 1'b0; v.dl = 1'b0; v.da = 32'h0; v.dd = 32'h0; v.ds = 2'd0;
        v.md = 32'h0; v.e_ctl = 10'h000;
        v.e_crd = 32'h0; v.e_drd = 32'h0; v.e_maddr = 32'h0; v.e_mdin = 32'h0;
        return v;
    endfunction

    function automatic logic [9:0] ctl(input logic cg, input logic crv, input logic cst,
                                       input logic dg, input logic drv, input logic mw,
                                       input logic mr, input logic [1:0] sz, input logic sg);
        return {cg, crv, cst, dg, drv, mw, mr, sz, sg};
    endfunction

    task automatic drive(input vec_t v);
        CPU_REQ = v.cr; CPU_WE = v.cwe; CPU_ADDR = v.ca; CPU_DIN = v.cd; CPU_SIZE = v.cs; CPU_SIGN = v.csg;
        DMA_REQ = v.dr; DMA_WE = v.dwe; DMA_ADDR = v.da; DMA_DIN = v.dd; DMA_SIZE = v.ds; DMA_SIGN = v.dsg;
        DMA_LOCK = v.dl; MEM_DOUT2 = v.md;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " ctl"}, {54'd0, CPU_GNT, CPU_RVALID, CPU_STALL, DMA_GNT, DMA_RVALID,
                           MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN}, 64'd0);
        chk({nm, " rdata"}, {CPU_RDATA, DMA_RDATA}, 64'd0);
        chk({nm, " mem"}, {MEM_ADDR2, MEM_DIN2}, 64'd0);
    endtask

    initial begin
        vec_t v;
        logic exp_cg, prev_cg;

        // ---- vector table ----
        v = vz(); vecs.push_back(v);                                        // 0 idle
        v = vz(); v.cr = 1'b1; v.ca = 32'h100; v.cs = 2'd2;                 // 1 lone CPU read
        v.e_ctl = ctl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0); v.e_maddr = 32'h100; vecs.push_back(v);
        v = vz(); v.md = 32'hDEAD_BEEF;                                     // 2 CPU read returns
        v.e_ctl = ctl(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0); v.e_crd = 32'hDEAD_BEEF; vecs.push_back(v);
        v = vz(); v.md = 32'h1234_5678; vecs.push_back(v);                 // 3 RVALID only one cycle
        for (int i = 0; i < 4; i++) begin                                   // 4..7 contested reads
            v = vz(); v.cr = 1'b1; v.ca = 32'h200; v.cs = 2'd2;
            v.dr = 1'b1; v.da = 32'h300; v.ds = 2'd1; v.dsg = 1'b1;
            if (i == 0) v.md = 32'h0; else v.md = 32'hA000_0000 + i;
            if ((i % 2) == 0) begin
                v.e_ctl = ctl(1'b1, 1'b0, 1'b0, 1'b0, (i != 0), 1'b0, 1'b1, 2'd2, 1'b0);
                v.e_maddr = 32'h200;
                if (i != 0) v.e_drd = v.md;
            end else begin
                v.e_ctl = ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
                v.e_maddr = 32'h300; v.e_crd = v.md;
            end
            vecs.push_back(v);
        end
        v = vz(); v.md = 32'hD000_0004;                                     // 8 last DMA return
        v.e_ctl = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0); v.e_drd = 32'hD000_0004; vecs.push_back(v);
        v = vz(); v.cr = 1'b1; v.cwe = 1'b1; v.ca = 32'h203; v.cd = 32'h55; v.cs = 2'd0; // 9 CPU byte write
        v.e_ctl = ctl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,1'b0); v.e_maddr = 32'h203; v.e_mdin = 32'h55;
        vecs.push_back(v);
        v = vz(); v.md = 32'hFFFF_FFFF; vecs.push_back(v);                 // 10 no RVALID after write
        v = vz(); v.dr = 1'b1; v.dwe = 1'b1; v.da = 32'h400; v.dd = 32'h99; v.ds = 2'd2; // 11 DMA write
        v.e_ctl = ctl(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd2,1'b0); v.e_maddr = 32'h400; v.e_mdin = 32'h99;
        vecs.push_back(v);
        v = vz(); v.md = 32'h0000_1111; vecs.push_back(v);                 // 12 idle

        // ---- reset with inputs active: every output held at 0 ----
        v = vz(); drive(v);
        RST_N = 1'b0;
        CPU_REQ = 1'b1; CPU_ADDR = 32'h10; DMA_REQ = 1'b1; DMA_LOCK = 1'b1; MEM_DOUT2 = 32'hFFFF_FFFF;
        repeat (2) @(negedge CLK);
        #1 chk_all_zero("in_reset");
        @(negedge CLK);
        v = vz(); drive(v);
        RST_N = 1'b1;

        // ---- table application ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d ctl", i),
                {54'd0, CPU_GNT, CPU_RVALID, CPU_STALL, DMA_GNT, DMA_RVALID, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN},
                {54'd0, vecs[i].e_ctl});
            chk($sformatf("vec%0d rdata", i), {CPU_RDATA, DMA_RDATA}, {vecs[i].e_crd, vecs[i].e_drd});
            chk($sformatf("vec%0d mem", i), {MEM_ADDR2, MEM_DIN2}, {vecs[i].e_maddr, vecs[i].e_mdin});
        end

        // ---- locked DMA write burst, CPU reading throughout ----
        @(negedge CLK);
        v = vz(); v.dr = 1'b1; v.dwe = 1'b1; v.da = 32'h800; v.dd = 32'hCAFE; v.ds = 2'd2; v.dl = 1'b1;
        drive(v);
        #1 chk("lock_entry gnt", {62'd0, CPU_GNT, DMA_GNT}, {62'd0, 1'b0, 1'b1});
        prev_cg = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h1000 + k; MEM_DOUT2 = 32'h5000_0000 + k;
            #1;
            exp_cg = ((k % 9) == 8);
            chk($sformatf("lock k%0d ctl", k),
                {58'd0, CPU_GNT, DMA_GNT, CPU_STALL, CPU_RVALID, MEM_READ2, MEM_WRITE2},
                {58'd0, exp_cg, !exp_cg, !exp_cg, prev_cg, exp_cg, !exp_cg});
            chk($sformatf("lock k%0d rdata", k), {32'd0, CPU_RDATA},
                {32'd0, (prev_cg ? (32'h5000_0000 + k) : 32'h0)});
            prev_cg = exp_cg;
        end

        // ---- lock drops with both requesting: round-robin gives CPU the port ----
        @(negedge CLK);
        DMA_LOCK = 1'b0; CPU_ADDR = 32'h2000; MEM_DOUT2 = 32'h0;
        #1 chk("lock_exit", {61'd0, CPU_GNT, DMA_GNT, CPU_STALL}, {61'd0, 1'b1, 1'b0, 1'b0});

        // ---- lone CPU read, then reset the following cycle ----
        @(negedge CLK);
        DMA_REQ = 1'b0; CPU_ADDR = 32'h3000; MEM_DOUT2 = 32'h77;
        #1 chk("pre_reset read", {32'd0, 29'd0, CPU_GNT, CPU_RVALID, DMA_GNT, CPU_RDATA},
               {32'd0, 29'd0, 1'b1, 1'b1, 1'b0, 32'h77});
        @(negedge CLK);
        RST_N = 1'b0; CPU_REQ = 1'b1; DMA_REQ = 1'b1; MEM_DOUT2 = 32'h88;
        #1 chk_all_zero("reset_inflight");
        @(negedge CLK);
        RST_N = 1'b1; CPU_REQ = 1'b0; DMA_REQ = 1'b0;
        #1 chk("post_reset no rvalid", {62'd0, CPU_RVALID, DMA_RVALID}, 64'd0);
        @(negedge CLK);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; DMA_REQ = 1'b1; DMA_WE = 1'b0;
        #1 chk("post_reset first conflict", {62'd0, CPU_GNT, DMA_GNT}, {62'd0, 1'b1, 1'b0});
        @(negedge CLK);
        v = vz(); drive(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
